// File: rtl/state_dump_pkg.sv
// Shared types and constants for the end-of-run state dump controller.
package state_dump_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_DUMP_REG = 3'd1,
    ST_DUMP_MEM = 3'd2,
    ST_END      = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic [1:0] TAG_PC  = 2'b00;
  localparam logic [1:0] TAG_REG = 2'b01;
  localparam logic [1:0] TAG_MEM = 2'b10;
  localparam logic [1:0] TAG_END = 2'b11;

  localparam logic [1:0] RSN_NONE    = 2'b00;
  localparam logic [1:0] RSN_ZERO    = 2'b01;
  localparam logic [1:0] RSN_HALT    = 2'b10;
  localparam logic [1:0] RSN_TIMEOUT = 2'b11;

  // Priority encoder: zero instruction beats halt, halt beats timeout.
  function automatic logic [1:0] stop_code(input logic zero_inst,
                                           input logic halt,
                                           input logic timeout);
    logic [1:0] code;
    if (zero_inst) begin
      code = RSN_ZERO;
    end else if (halt) begin
      code = RSN_HALT;
    end else if (timeout) begin
      code = RSN_TIMEOUT;
    end else begin
      code = RSN_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/dump_index_counter.sv
// Index counter with clear, enable and wrap-to-zero at a terminal value.
module dump_index_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         at_last
);

  logic [W-1:0] count_r;

  assign count   = count_r;
  assign at_last = (count_r == last);

  // Index register; wraps to zero after the terminal beat so the next phase starts clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      count_r <= at_last ? {W{1'b0}} : count_r + W'(1'b1);
    end
  end

endmodule

// File: rtl/state_dump_ctrl.sv
// End-of-run controller: PC trace while running, then register/memory/end-marker dump.
module state_dump_ctrl
  import state_dump_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                NUM_REGS       = 32,
  parameter int                REG_AW         = 5,
  parameter int                MEM_AW         = 32,
  parameter logic [MEM_AW-1:0] MEM_BASE       = MEM_AW'(32'h4000),
  parameter int                MEM_WORDS      = 4,
  parameter int                TIMEOUT_CYCLES = 64,
  parameter bit                PC_TRACE       = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] inst,
  input  logic [DATA_W-1:0] pc,
  input  logic              halt_req,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_tag,
  output logic              cpu_stall,
  output logic [1:0]        stop_reason,
  output logic              done,
  output logic [31:0]       cycle_count
);

  localparam int                MEM_IW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [REG_AW-1:0] REG_LAST = REG_AW'(NUM_REGS - 1);
  localparam logic [MEM_IW-1:0] MEM_LAST = MEM_IW'(MEM_WORDS - 1);
  localparam logic [31:0]       CYC_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [31:0]       cycle_count_r;
  logic [1:0]        stop_reason_r;
  logic              done_r;
  logic [REG_AW-1:0] reg_idx_s;
  logic [MEM_IW-1:0] mem_idx_s;
  logic              reg_last_s;
  logic              mem_last_s;
  logic              handshake_s;
  logic              accept_s;
  logic              stop_s;
  logic [1:0]        stop_code_s;

  assign cycle_count = cycle_count_r;
  assign stop_reason = stop_reason_r;
  assign done        = done_r;

  assign handshake_s = out_valid && out_ready;
  // An accepted cycle is one where the machine really advanced.
  assign accept_s    = (state_r == ST_RUN) && !cpu_stall;
  assign stop_code_s = stop_code(inst == {DATA_W{1'b0}}, halt_req, cycle_count_r == CYC_LAST);
  assign stop_s      = accept_s && (stop_code_s != RSN_NONE);

  dump_index_counter #(.W(REG_AW)) u_reg_idx (
    .clk     (clk),
    .reset   (reset),
    .clr     (stop_s),
    .en      ((state_r == ST_DUMP_REG) && handshake_s),
    .last    (REG_LAST),
    .count   (reg_idx_s),
    .at_last (reg_last_s)
  );

  dump_index_counter #(.W(MEM_IW)) u_mem_idx (
    .clk     (clk),
    .reset   (reset),
    .clr     (stop_s),
    .en      ((state_r == ST_DUMP_MEM) && handshake_s),
    .last    (MEM_LAST),
    .count   (mem_idx_s),
    .at_last (mem_last_s)
  );

  // Stream, stall and read-address decode from the current state.
  always_comb begin
    out_valid = 1'b0;
    out_data  = {DATA_W{1'b0}};
    out_tag   = TAG_PC;
    cpu_stall = 1'b1;
    rf_raddr  = {REG_AW{1'b0}};
    mem_raddr = {MEM_AW{1'b0}};
    case (state_r)
      ST_RUN: begin
        out_valid = PC_TRACE;
        out_data  = pc;
        out_tag   = TAG_PC;
        cpu_stall = PC_TRACE && !out_ready;
      end
      ST_DUMP_REG: begin
        out_valid = 1'b1;
        rf_raddr  = reg_idx_s;
        out_data  = rf_rdata;
        out_tag   = TAG_REG;
      end
      ST_DUMP_MEM: begin
        out_valid = 1'b1;
        mem_raddr = MEM_BASE + MEM_AW'(mem_idx_s);
        out_data  = mem_rdata;
        out_tag   = TAG_MEM;
      end
      ST_END: begin
        out_valid = 1'b1;
        out_data  = DATA_W'(cycle_count_r);
        out_tag   = TAG_END;
      end
      ST_DONE: begin
        out_valid = 1'b0;
        out_tag   = TAG_END;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // Next-state selection; every dump phase advances only on a handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (stop_s) begin
          state_nxt_s = ST_DUMP_REG;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DUMP_REG: begin
        if (handshake_s && reg_last_s) begin
          state_nxt_s = ST_DUMP_MEM;
        end else begin
          state_nxt_s = ST_DUMP_REG;
        end
      end
      ST_DUMP_MEM: begin
        if (handshake_s && mem_last_s) begin
          state_nxt_s = ST_END;
        end else begin
          state_nxt_s = ST_DUMP_MEM;
        end
      end
      ST_END: begin
        if (handshake_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_END;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // State, saturating run-cycle counter, latched stop reason and done flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_RUN;
      cycle_count_r <= 32'h0000_0000;
      stop_reason_r <= RSN_NONE;
      done_r        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s && (cycle_count_r != 32'hFFFF_FFFF)) begin
        cycle_count_r <= cycle_count_r + 32'd1;
      end
      if (stop_s) begin
        stop_reason_r <= stop_code_s;
      end
      if ((state_r == ST_END) && handshake_s) begin
        done_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_state_dump_ctrl.sv
// Self-checking bench for state_dump_ctrl: table of run scenarios against a beat-list model.
module tb_state_dump_ctrl;
  import state_dump_pkg::*;

  localparam int          NR = 32;
  localparam int          MW = 4;
  localparam int          TO = 64;
  localparam logic [31:0] MB = 32'h4000;

  logic        clk = 1'b0;
  logic        reset, halt_req, out_valid, out_ready, cpu_stall, done;
  logic [31:0] inst, pc, rf_rdata, mem_raddr, mem_rdata, out_data, cycle_count;
  logic [4:0]  rf_raddr;
  logic [1:0]  out_tag, stop_reason;

  logic        reset2, halt2, valid2, ready2, stall2, done2;
  logic [31:0] inst2, pc2, rf_rdata2, mem_raddr2, mem_rdata2, data2, count2;
  logic [4:0]  rf_raddr2;
  logic [1:0]  tag2, reason2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] reg_val(input logic [4:0] i);
    return 32'hC0DE_0000 + 32'(i) * 32'd257;
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign rf_rdata   = reg_val(rf_raddr);
  assign mem_rdata  = mem_val(mem_raddr);
  assign rf_rdata2  = reg_val(rf_raddr2);
  assign mem_rdata2 = mem_val(mem_raddr2);

  state_dump_ctrl dut (
    .clk(clk), .reset(reset), .inst(inst), .pc(pc), .halt_req(halt_req),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .cpu_stall(cpu_stall), .stop_reason(stop_reason), .done(done), .cycle_count(cycle_count)
  );

  state_dump_ctrl #(.MEM_WORDS(1), .PC_TRACE(1'b0)) dut2 (
    .clk(clk), .reset(reset2), .inst(inst2), .pc(pc2), .halt_req(halt2),
    .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2), .mem_raddr(mem_raddr2), .mem_rdata(mem_rdata2),
    .out_valid(valid2), .out_ready(ready2), .out_data(data2), .out_tag(tag2),
    .cpu_stall(stall2), .stop_reason(reason2), .done(done2), .cycle_count(count2)
  );

  typedef struct {
    int          zero_at;   // accepted-cycle index carrying inst == 0 (-1: never)
    int          halt_at;   // accepted-cycle index with halt_req (-1: never)
    int          run_rdy;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
    int          dump_rdy;
    logic [1:0]  exp_rsn;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t        vecs[9];
  logic [33:0] expq[$];
  logic [33:0] gotq[$];
  logic        hold_pending;
  logic [33:0] held;
  int          nregs_got;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic rdy_val(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c % 4) == 0) || ((c % 4) == 3);
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Called at the falling edge: hold check under backpressure and beat capture.
  task automatic sample();
    if (hold_pending) chk("hold_beat", {out_tag, out_data}, held);
    hold_pending = out_valid && !out_ready;
    held = {out_tag, out_data};
    if (out_valid && out_ready) begin
      gotq.push_back({out_tag, out_data});
      if (out_tag == TAG_REG) nregs_got++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int abort_reg);
    int          k;
    logic        running;
    logic [1:0]  rsn;
    logic [31:0] pc0;
    expq.delete();
    gotq.delete();
    hold_pending = 1'b0;
    nregs_got = 0;
    reset = 1'b1; out_ready = 1'b0; inst = 32'h1; halt_req = 1'b0; pc = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_valid", out_valid, 1);
    chk("rst_tag", out_tag, TAG_PC);
    chk("rst_stall_busy", cpu_stall, 1);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_rsn", stop_reason, RSN_NONE);
    chk("rst_done", done, 0);
    out_ready = 1'b1;
    #1 chk("rst_stall_rdy", cpu_stall, 0);
    @(posedge clk); #1 reset = 1'b0;

    k = 0; running = 1'b1; rsn = RSN_NONE;
    pc0 = $urandom & 32'hFFFF_FFFC;
    for (int c = 0; c < 400 && running; c++) begin
      out_ready = rdy_val(v.run_rdy, c);
      inst      = (k == v.zero_at) ? 32'h0 : 32'hA000_0001 + 32'(k) * 32'd8;
      halt_req  = (k == v.halt_at);
      pc        = pc0 + 32'(k) * 32'd4;
      @(negedge clk);
      sample();
      chk("run_stall", cpu_stall, !out_ready);
      chk("run_cnt", cycle_count, 64'(k));
      chk("run_raddr", {rf_raddr, mem_raddr}, 0);
      if (out_ready) begin
        expq.push_back({TAG_PC, pc});
        k++;
        if (inst == 32'h0) rsn = RSN_ZERO;
        else if (halt_req) rsn = RSN_HALT;
        else if (k == TO) rsn = RSN_TIMEOUT;
        if (rsn != RSN_NONE) running = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("run_stopped", running, 0);

    for (int i = 0; i < NR; i++) expq.push_back({TAG_REG, reg_val(5'(i))});
    for (int i = 0; i < MW; i++) expq.push_back({TAG_MEM, mem_val(MB + 32'(i))});
    expq.push_back({TAG_END, 32'(k)});

    inst = 32'h0; halt_req = 1'b1;
    for (int j = 0; j < 600; j++) begin
      if (done) break;
      out_ready = rdy_val(v.dump_rdy, j);
      @(negedge clk);
      if (abort_reg >= 0 && out_valid && out_tag == TAG_REG && nregs_got == abort_reg) begin
        #2 reset = 1'b1;
        #1;
        chk("abort_tag", out_tag, TAG_PC);
        chk("abort_valid", out_valid, 1);
        chk("abort_cnt", cycle_count, 0);
        chk("abort_done", done, 0);
        chk("abort_rsn", stop_reason, RSN_NONE);
        chk("abort_raddr", rf_raddr, 0);
        chk("abort_regs_seen", gotq.size(), 64'(k + abort_reg));
        return;
      end
      sample();
      chk("dump_stall", cpu_stall, 1);
      chk("dump_cnt", cycle_count, 64'(k));
      @(posedge clk); #1;
    end

    @(negedge clk);
    chk("done", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_stall", cpu_stall, 1);
    chk("stop_reason", stop_reason, v.exp_rsn);
    chk("stop_reason_model", stop_reason, rsn);
    chk("end_cnt", cycle_count, v.exp_cnt);
    inst = 32'h5; halt_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("done_held", {done, out_valid}, 2'b10);
    chk("beat_count", gotq.size(), expq.size());
    for (int i = 0; i < gotq.size() && i < expq.size(); i++)
      chk($sformatf("beat%0d", i), gotq[i], expq[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] q2[$];
    logic [33:0] e2[$];
    reset = 1'b1; out_ready = 1'b0; inst = 32'h1; halt_req = 1'b0; pc = 32'h0;
    reset2 = 1'b1; ready2 = 1'b0; inst2 = 32'h1; halt2 = 1'b0; pc2 = 32'h0;

    vecs[0] = '{5, -1, 0, 0, RSN_ZERO, 32'd6};
    vecs[1] = '{-1, -1, 0, 0, RSN_TIMEOUT, 32'd64};
    vecs[2] = '{3, 3, 0, 0, RSN_ZERO, 32'd4};
    vecs[3] = '{-1, 9, 0, 0, RSN_HALT, 32'd10};
    vecs[4] = '{7, -1, 1, 1, RSN_ZERO, 32'd8};
    vecs[5] = '{-1, 20, 2, 2, RSN_HALT, 32'd21};
    vecs[6] = '{0, -1, 0, 1, RSN_ZERO, 32'd1};
    vecs[7] = '{-1, 63, 1, 0, RSN_HALT, 32'd64};
    vecs[8] = '{63, -1, 2, 2, RSN_ZERO, 32'd64};

    run_vec('{2, -1, 0, 0, RSN_ZERO, 32'd3}, 10);
    for (int i = 0; i < 9; i++) run_vec(vecs[i], -1);

    // No trace and a one-word memory window: only the dump beats appear.
    @(posedge clk); #1 reset2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      inst2  = (c == 3) ? 32'h0 : 32'h1234_0000 + 32'(c);
      pc2    = 32'h100 + 32'(c) * 32'd4;
      ready2 = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("nt_valid", valid2, 0);
      chk("nt_stall", stall2, 0);
      chk("nt_cnt", count2, 64'(c));
      @(posedge clk); #1;
    end
    for (int i = 0; i < NR; i++) e2.push_back({TAG_REG, reg_val(5'(i))});
    e2.push_back({TAG_MEM, mem_val(MB)});
    e2.push_back({TAG_END, 32'd4});
    for (int j = 0; j < 300; j++) begin
      if (done2) break;
      ready2 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (valid2 && ready2) q2.push_back({tag2, data2});
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("nt_done", done2, 1);
    chk("nt_reason", reason2, RSN_ZERO);
    chk("nt_beat_count", q2.size(), 34);
    for (int i = 0; i < q2.size() && i < e2.size(); i++)
      chk($sformatf("nt_beat%0d", i), q2[i], e2[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
